// File: rtl/bp_pkg.sv
// Shared definitions for the backpropagation weight-update block:
// fixed-point defaults, controller states and the saturating adder.
package bp_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int FRAC_DEF  = 16;
    localparam logic signed [WIDTH_DEF-1:0] ONE = WIDTH_DEF'(1) <<< FRAC_DEF;

    // Wide carrier so the same adder serves any WIDTH up to SATW-1 bits.
    localparam int SATW = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DERIV  = 3'd1,
        DELTA  = 3'd2,
        SCALE  = 3'd3,
        UPDATE = 3'd4,
        WRITE  = 3'd5
    } state_t;

    function automatic logic signed [SATW-1:0] sat_add(
        input logic signed [SATW-1:0] a,
        input logic signed [SATW-1:0] b,
        input logic                   sub,
        input int unsigned            w
    );
        logic signed [SATW:0] s;
        logic signed [SATW:0] hi;
        logic signed [SATW:0] lo;
        s  = sub ? ({a[SATW-1], a} - {b[SATW-1], b}) : ({a[SATW-1], a} + {b[SATW-1], b});
        hi = 1;
        hi = (hi <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (s > hi)
            return hi[SATW-1:0];
        else if (s < lo)
            return lo[SATW-1:0];
        else
            return s[SATW-1:0];
    endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// Combinational signed fixed-point multiply: full-width product, arithmetic
// shift by FRAC (floor), saturate back to WIDTH bits.
module fxp_mul_sat #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);

    localparam int PW = 2 * WIDTH;
    localparam logic signed [PW-1:0] MAXV = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    always_comb begin
        prod    = PW'(a) * PW'(b);
        shifted = prod >>> FRAC;
        if (shifted > MAXV)
            y = WIDTH'(MAXV);
        else if (shifted < MINV)
            y = WIDTH'(MINV);
        else
            y = WIDTH'(shifted);
    end

endmodule

// File: rtl/bp_weight_update.sv
// Sequential backprop update: delta = err*a*(1-a), w_j += lr*delta*k_j,
// b += lr*delta, using one shared multiplier and one shared saturating adder.
module bp_weight_update
    import bp_pkg::*;
#(
    parameter int NUM   = 2,
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic signed [WIDTH-1:0]   i_a,
    input  logic signed [WIDTH-1:0]   i_err,
    input  logic [NUM*WIDTH-1:0]      i_k,
    input  logic [NUM*WIDTH-1:0]      i_w,
    input  logic signed [WIDTH-1:0]   i_b,
    input  logic signed [WIDTH-1:0]   i_lr,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_wr,
    output logic [(NUM+1)*WIDTH-1:0]  o_w,
    output logic signed [WIDTH-1:0]   o_delta
);

    localparam int IW = $clog2(NUM + 1);
    localparam logic signed [WIDTH-1:0] ONE_W = WIDTH'(1) <<< FRAC;

    state_t state, state_nx;
    logic [IW-1:0] idx;
    logic          idx_last;

    logic signed [WIDTH-1:0] a_r, om_r, err_r, lr_r, b_r, d_r, g_r, delta_r;
    logic [NUM*WIDTH-1:0]    k_r, w_r, shadow;
    logic [(NUM+1)*WIDTH-1:0] w_out;

    logic signed [WIDTH-1:0] mul_a, mul_b, mul_y;
    logic signed [WIDTH-1:0] add_x, add_y, add_res;
    logic                    add_sub;

    assign idx_last = (idx == IW'(NUM));

    fxp_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
        .a (mul_a),
        .b (mul_b),
        .y (mul_y)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start) state_nx = DERIV;
            DERIV:   state_nx = DELTA;
            DELTA:   state_nx = SCALE;
            SCALE:   state_nx = UPDATE;
            UPDATE:  if (idx_last) state_nx = WRITE;
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != IDLE);
        o_wr   = (state == WRITE);
        o_done = (state == WRITE);
    end

    // Multiplier operands come only from registers, so the mul/add chain never loops.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            DERIV:  begin mul_a = a_r;   mul_b = om_r;    end
            DELTA:  begin mul_a = err_r; mul_b = d_r;     end
            SCALE:  begin mul_a = lr_r;  mul_b = delta_r; end
            UPDATE: if (!idx_last) begin
                        mul_a = g_r;
                        mul_b = k_r[int'(idx)*WIDTH +: WIDTH];
                    end
            default: ;
        endcase
    end

    // (ONE - a) is formed by the adder while idle, at the accepting edge.
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_sub = 1'b0;
        case (state)
            IDLE: begin
                add_x   = ONE_W;
                add_y   = i_a;
                add_sub = 1'b1;
            end
            UPDATE: begin
                if (idx_last) begin
                    add_x = b_r;
                    add_y = g_r;
                end else begin
                    add_x = w_r[int'(idx)*WIDTH +: WIDTH];
                    add_y = mul_y;
                end
            end
            default: ;
        endcase
        add_res = WIDTH'(sat_add(SATW'(add_x), SATW'(add_y), add_sub, WIDTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            a_r     <= '0;
            om_r    <= '0;
            err_r   <= '0;
            lr_r    <= '0;
            b_r     <= '0;
            d_r     <= '0;
            g_r     <= '0;
            delta_r <= '0;
            k_r     <= '0;
            w_r     <= '0;
            shadow  <= '0;
            w_out   <= '0;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    a_r   <= i_a;
                    om_r  <= add_res;
                    err_r <= i_err;
                    lr_r  <= i_lr;
                    b_r   <= i_b;
                    k_r   <= i_k;
                    w_r   <= i_w;
                    idx   <= '0;
                end
                DERIV: d_r     <= mul_y;
                DELTA: delta_r <= mul_y;
                SCALE: g_r     <= mul_y;
                UPDATE: begin
                    idx <= idx + IW'(1);
                    if (idx_last)
                        w_out <= {add_res, shadow};
                    else
                        shadow[int'(idx)*WIDTH +: WIDTH] <= add_res;
                end
                default: ;
            endcase
        end
    end

    assign o_w     = w_out;
    assign o_delta = delta_r;

endmodule
